car_monitor_n: RTL and testbench
================================

Name: car_monitor_n

Overview:
- Parametrised N-lane intersection monitor. Successor to the per-lane car-simulation blocks: one instance covers every lane.
- Clocked, not combinational. Contains an internal 4 Hz blink generator, a per-lane violation state machine with post-event warning hold, and per-lane saturating violation counters.
- Sits between the traffic-light sequencer (supplies Signal_Pos and light_out_time) and the board LEDs, buzzer and velocity display.

Parameters:
- N_LANES, 4, number of lanes/cars monitored (2..8).
- VEL_W, 6, velocity width per lane, unsigned.
- SPEED_LIMIT, 31, overspeed threshold; violation when velocity >= SPEED_LIMIT.
- CLK_DIV, 6250000, system clocks per blink half-period (4 Hz square wave at 50 MHz).
- HOLD_TICKS, 8, blink half-periods a warning persists after its cause ends.
- CNT_W, 8, width of each violation counter.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_n  in  1  asynchronous active-low reset.
- Switch  in  N_LANES  bit i=1: car present at lane i stop line.
- Signal_Pos  in  clog2(N_LANES)  index of the lane holding green.
- In_velocity  in  N_LANES*VEL_W  lane i velocity in bits [i*VEL_W +: VEL_W].
- light_out_time  in  1  1 = lights out, monitoring suspended.
- Clr_cnt  in  1  synchronous clear of all counters.
- vel_visibility  out  N_LANES  lane i velocity display enable.
- buz_position  out  N_LANES  lane i overspeed indicator, blinking.
- Warn_led  out  N_LANES  lane i red-light-run indicator, blinking.
- Speed_cnt  out  N_LANES*CNT_W  per-lane overspeed event count.
- Red_cnt  out  N_LANES*CNT_W  per-lane red-run event count.

Behaviour:
- Reset (async, RST_n=0):
  - All states IDLE; hold counters, divider and blink = 0.
  - All counters 0; all outputs 0.
- Blink generator:
  - Divider counts 0..CLK_DIV-1.
  - tick is a 1-cycle pulse at CLK_DIV-1; divider wraps to 0 on tick; blink toggles on tick.
  - light_out_time=1: divider and blink held at 0.
- Per-lane definitions, sampled each clock:
  - car = Switch[i]
  - green = (Signal_Pos == i)
  - over = velocity >= SPEED_LIMIT, unsigned full-width compare.
- States: IDLE, PASS, SPEED, RED, HOLD. HOLD carries kind bit K (0 = speed, 1 = red) and counter H.
- light_out_time=1: every lane goes to IDLE next cycle and H is cleared. Counters are retained.
- Transitions (priority top-down; applied from any state when light_out_time=0):
  - car & ~green -> RED.
  - car & green & over -> SPEED.
  - From SPEED, if neither of the above holds -> HOLD, K=0, H=HOLD_TICKS.
  - From RED, if neither of the above holds -> HOLD, K=1, H=HOLD_TICKS.
  - In HOLD: H decrements on tick; when H=0 -> IDLE. A HOLD that re-enters SPEED or RED overrides K.
  - IDLE/PASS: car & green & ~over -> PASS; ~car -> IDLE.
- Signal_Pos >= N_LANES: no lane is green, so every present car is a red violation.
- Outputs, combinational from registers only (state, blink, and registered copies of car/green):
  - vel_visibility[i] = car & green & ~light_out_time, registered, 1-cycle latency.
  - buz_position[i] = blink & (SPEED | (HOLD & K=0)).
  - Warn_led[i] = blink & (RED | (HOLD & K=1)).
- Latency: input change -> state/outputs update on the next rising edge.
- Counters:
  - Speed_cnt[i] increments once per entry into SPEED from any other state, including HOLD.
  - Red_cnt[i] increments once per entry into RED from any other state.
  - Both saturate at 2^CNT_W-1.
  - Clr_cnt has priority over a same-cycle increment; that increment is lost.
- Green moves away from an occupied lane: PASS -> RED in one cycle, counted.

Optional Feature:
- Macro: CAR_MON_CNT_EN.
- Defined: Speed_cnt, Red_cnt and Clr_cnt behave as above.
- Undefined: no counter registers are built; Speed_cnt and Red_cnt are tied to 0; Clr_cnt is ignored. All ports remain present.

Decomposition:
- Shared package/include car_mon_pkg:
  - State encoding (IDLE=0, PASS=1, SPEED=2, RED=3, HOLD=4).
  - Default SPEED_LIMIT and CLK_DIV constants.
- Sub-module car_blink_gen: divider, tick, blink; CLK_DIV parameter; light_out_time hold input. Instantiated once.
- Per-lane FSM and counters live in a generate loop; no separate module.

Test Plan (sim with CLK_DIV=4, HOLD_TICKS=2, N_LANES=4):
- Reset: release RST_n with Switch=4'b1111 -> all outputs 0 during reset; counters 0; lanes 1..3 RED and lane 0 state set by velocity one cycle after release.
- Overspeed: Signal_Pos=2, Switch[2]=1, vel2=31 -> vel_visibility[2]=1, buz_position[2] toggles every 4 clocks, Speed_cnt[2]=1. vel2=30 -> stays blinking 2 ticks (8 clocks), then IDLE, buz=0.
- Red run: Signal_Pos=0, Switch[3]=1 -> Warn_led[3] blinks, Red_cnt[3]=1. Signal_Pos=3 with vel3=10 -> PASS, Warn_led[3]=0, vel_visibility[3]=1, Red_cnt stays 1.
- Light change under car: lane 1 PASS, Signal_Pos 1->2 -> RED next cycle, Red_cnt[1]+1.
- Lights out mid-HOLD: light_out_time=1 -> all outputs 0 next cycle, blink 0, counters unchanged; release -> no spurious counts with Switch=0.
- Saturation/clear: CNT_W=2, four speed entries -> Speed_cnt=3. Clr_cnt coincident with a new entry -> 0.

Source files
------------

// File: rtl/car_mon_pkg.sv
// Shared definitions for the N-lane intersection monitor: lane state
// encoding, HOLD kind values and default timing/threshold constants.
package car_mon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PASS  = 3'd1,
        ST_SPEED = 3'd2,
        ST_RED   = 3'd3,
        ST_HOLD  = 3'd4
    } lane_state_e;

    // Kind bit carried by HOLD: which warning is being held.
    localparam logic KIND_SPEED = 1'b0;
    localparam logic KIND_RED   = 1'b1;

    localparam int DEF_SPEED_LIMIT = 31;
    localparam int DEF_CLK_DIV     = 6250000;

endpackage

// File: rtl/car_blink_gen.sv
// Blink generator: divider counting 0..CLK_DIV-1, a one-cycle tick on the
// last count and a square-wave blink that toggles on each tick. Lights-out
// holds divider and blink at 0 so every lit period starts in a known phase.
module car_blink_gen
    import car_mon_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic light_out_time,
    output logic tick,
    output logic blink
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div;

    assign tick = ~light_out_time && (div == DIV_LAST);

    // Divider and blink toggle; both forced to 0 while lights are out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div   <= '0;
            blink <= 1'b0;
        end else if (light_out_time) begin
            div   <= '0;
            blink <= 1'b0;
        end else if (tick) begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge values, independent of block order.
            div   <= '0;
            blink <= ~blink;
        end else begin
            div   <= div + DIV_W'(1);
        end
    end

endmodule

// File: rtl/car_monitor_n.sv
// N-lane intersection monitor. One violation FSM per lane (IDLE, PASS,
// SPEED, RED, HOLD) with a blink-tick timed warning hold, a registered
// velocity display enable and, when CAR_MON_CNT_EN is defined, per-lane
// saturating overspeed and red-run entry counters. With CAR_MON_CNT_EN
// undefined no counters are built, Speed_cnt/Red_cnt read 0 and Clr_cnt
// is ignored.
module car_monitor_n
    import car_mon_pkg::*;
#(
    parameter int N_LANES     = 4,
    parameter int VEL_W       = 6,
    parameter int SPEED_LIMIT = DEF_SPEED_LIMIT,
    parameter int CLK_DIV     = DEF_CLK_DIV,
    parameter int HOLD_TICKS  = 8,
    parameter int CNT_W       = 8,
    localparam int POS_W      = $clog2(N_LANES)
) (
    input  logic                       CLK,
    input  logic                       RST_n,
    input  logic [N_LANES-1:0]         Switch,
    input  logic [POS_W-1:0]           Signal_Pos,
    input  logic [N_LANES*VEL_W-1:0]   In_velocity,
    input  logic                       light_out_time,
    input  logic                       Clr_cnt,
    output logic [N_LANES-1:0]         vel_visibility,
    output logic [N_LANES-1:0]         buz_position,
    output logic [N_LANES-1:0]         Warn_led,
    output logic [N_LANES*CNT_W-1:0]   Speed_cnt,
    output logic [N_LANES*CNT_W-1:0]   Red_cnt
);

    localparam int HW = $clog2(HOLD_TICKS + 1);

    logic tick;
    logic blink;

    car_blink_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_blink (
        .clk           (CLK),
        .rst_n         (RST_n),
        .light_out_time(light_out_time),
        .tick          (tick),
        .blink         (blink)
    );

`ifndef CAR_MON_CNT_EN
    logic unused_clr;
    assign unused_clr = Clr_cnt;
`endif

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        lane_state_e    state, state_nxt;
        logic           kind, kind_nxt;
        logic [HW-1:0]  hold, hold_nxt;
        logic           vis_q;
        logic           car, green, over;

        assign car   = Switch[i];
        assign green = (Signal_Pos == POS_W'(i));
        assign over  = (32'(In_velocity[i*VEL_W +: VEL_W]) >= 32'(SPEED_LIMIT));

        // Next-state selection in priority order: red run, overspeed, then
        // per-state behaviour (hold entry, hold countdown, pass/idle).
        always_comb begin
            // NOTE: every variable gets a default first so no path leaves it
            // unassigned, which would otherwise infer a latch.
            state_nxt = state;
            kind_nxt  = kind;
            hold_nxt  = hold;
            if (light_out_time) begin
                state_nxt = ST_IDLE;
                hold_nxt  = '0;
            end else if (car && !green) begin
                state_nxt = ST_RED;
                kind_nxt  = KIND_RED;
            end else if (car && over) begin
                state_nxt = ST_SPEED;
                kind_nxt  = KIND_SPEED;
            end else begin
                case (state)
                    ST_SPEED: begin
                        state_nxt = ST_HOLD;
                        kind_nxt  = KIND_SPEED;
                        hold_nxt  = HW'(HOLD_TICKS);
                    end
                    ST_RED: begin
                        state_nxt = ST_HOLD;
                        kind_nxt  = KIND_RED;
                        hold_nxt  = HW'(HOLD_TICKS);
                    end
                    ST_HOLD: begin
                        if (hold == '0) state_nxt = ST_IDLE;
                        else if (tick)  hold_nxt  = hold - HW'(1);
                    end
                    default: state_nxt = car ? ST_PASS : ST_IDLE;
                endcase
            end
        end

        // Lane state, hold kind/counter and registered display enable.
        always_ff @(posedge CLK or negedge RST_n) begin
            if (!RST_n) begin
                state <= ST_IDLE;
                kind  <= KIND_SPEED;
                hold  <= '0;
                vis_q <= 1'b0;
            end else begin
                state <= state_nxt;
                kind  <= kind_nxt;
                hold  <= hold_nxt;
                vis_q <= car && green && !light_out_time;
            end
        end

        assign vel_visibility[i] = vis_q;
        assign buz_position[i]   = blink && ((state == ST_SPEED) ||
                                             ((state == ST_HOLD) && (kind == KIND_SPEED)));
        assign Warn_led[i]       = blink && ((state == ST_RED) ||
                                             ((state == ST_HOLD) && (kind == KIND_RED)));

`ifdef CAR_MON_CNT_EN
        logic [CNT_W-1:0] spd_cnt, red_cnt;
        logic             spd_entry, red_entry;

        assign spd_entry = (state_nxt == ST_SPEED) && (state != ST_SPEED);
        assign red_entry = (state_nxt == ST_RED)   && (state != ST_RED);

        // Saturating entry counters; clear wins over a same-cycle entry.
        always_ff @(posedge CLK or negedge RST_n) begin
            if (!RST_n) begin
                spd_cnt <= '0;
                red_cnt <= '0;
            end else if (Clr_cnt) begin
                spd_cnt <= '0;
                red_cnt <= '0;
            end else begin
                if (spd_entry && (spd_cnt != '1)) spd_cnt <= spd_cnt + CNT_W'(1);
                if (red_entry && (red_cnt != '1)) red_cnt <= red_cnt + CNT_W'(1);
            end
        end

        assign Speed_cnt[i*CNT_W +: CNT_W] = spd_cnt;
        assign Red_cnt[i*CNT_W +: CNT_W]   = red_cnt;
`else
        assign Speed_cnt[i*CNT_W +: CNT_W] = '0;
        assign Red_cnt[i*CNT_W +: CNT_W]   = '0;
`endif
    end

endmodule

// File: tb/tb_car_monitor_n.sv
// Scoreboard bench for car_monitor_n (N_LANES=4, CLK_DIV=4, HOLD_TICKS=2,
// CNT_W=2). Stimulus pushes hand-computed expectations tagged with the
// cycle they apply to; a monitor on the falling edge pops and compares.
module tb_car_monitor_n;

    localparam int N_LANES = 4;
    localparam int VEL_W   = 6;
    localparam int CNT_W   = 2;

    typedef enum int {K_VIS, K_BUZ, K_WARN, K_SPD, K_RED, K_VISV, K_BUZV, K_WARNV} kind_e;

    typedef struct {
        int    at;
        kind_e kind;
        int    lane;
        int    val;
        string name;
    } exp_t;

    logic                     clk;
    logic                     rst_n;
    logic [N_LANES-1:0]       sw;
    logic [1:0]               signal_pos;
    logic [N_LANES*VEL_W-1:0] in_velocity;
    logic                     lot;
    logic                     clr_cnt;
    logic [N_LANES-1:0]       vis, buz, warn;
    logic [N_LANES*CNT_W-1:0] speed_cnt, red_cnt;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];
    exp_t keep[$];

    car_monitor_n #(
        .N_LANES    (N_LANES),
        .VEL_W      (VEL_W),
        .SPEED_LIMIT(31),
        .CLK_DIV    (4),
        .HOLD_TICKS (2),
        .CNT_W      (CNT_W)
    ) dut (
        .CLK           (clk),
        .RST_n         (rst_n),
        .Switch        (sw),
        .Signal_Pos    (signal_pos),
        .In_velocity   (in_velocity),
        .light_out_time(lot),
        .Clr_cnt       (clr_cnt),
        .vel_visibility(vis),
        .buz_position  (buz),
        .Warn_led      (warn),
        .Speed_cnt     (speed_cnt),
        .Red_cnt       (red_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Counter expectations collapse to 0 when the counters are not built.
    function automatic int ce(input int v);
`ifdef CAR_MON_CNT_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    function automatic int actual(input kind_e k, input int lane);
        case (k)
            K_VIS:   return int'(vis[lane]);
            K_BUZ:   return int'(buz[lane]);
            K_WARN:  return int'(warn[lane]);
            K_SPD:   return int'(speed_cnt[lane*CNT_W +: CNT_W]);
            K_RED:   return int'(red_cnt[lane*CNT_W +: CNT_W]);
            K_VISV:  return int'(vis);
            K_BUZV:  return int'(buz);
            default: return int'(warn);
        endcase
    endfunction

    task automatic check(input exp_t e);
        int got;
        got = actual(e.kind, e.lane);
        n_checks++;
        if (got != e.val) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", e.name, cyc, got, e.val);
        end
    endtask

    // Monitor: compare every expectation due this cycle; overdue ones fail.
    always @(negedge clk) begin
        keep = {};
        foreach (sb[j]) begin
            if (sb[j].at == cyc) begin
                check(sb[j]);
            end else if (sb[j].at < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s: expected %0d at cycle %0d, never sampled", sb[j].name, sb[j].val, sb[j].at);
            end else begin
                keep.push_back(sb[j]);
            end
        end
        sb = keep;
    end

    task automatic push(input int at, input kind_e k, input int lane, input int val, input string name);
        exp_t e;
        e = '{at, k, lane, val, name};
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_vel(input int lane, input int v);
        in_velocity[lane*VEL_W +: VEL_W] = VEL_W'(v);
    endtask

    // One lights-out cycle: all lanes IDLE, divider and blink back to 0.
    task automatic sync_lights();
        lot = 1'b1;
        step(1);
        lot = 1'b0;
    endtask

    int s;

    initial begin
        rst_n       = 1'b0;
        sw          = 4'b1111;
        signal_pos  = 2'd0;
        in_velocity = '0;
        lot         = 1'b0;
        clr_cnt     = 1'b0;
        set_vel(0, 10);
        step(1);

        // Reset held with all cars present.
        push(cyc + 1, K_VISV,  0, 0, "reset_vis");
        push(cyc + 1, K_BUZV,  0, 0, "reset_buz");
        push(cyc + 1, K_WARNV, 0, 0, "reset_warn");
        push(cyc + 1, K_RED,   1, 0, "reset_red_cnt1");
        push(cyc + 1, K_SPD,   0, 0, "reset_spd_cnt0");
        step(2);

        // Release: lane 0 green and slow -> PASS; lanes 1..3 -> RED.
        rst_n = 1'b1;
        s = cyc;
        push(s + 1, K_VISV,  0, 4'b0001, "rel_vis");
        push(s + 1, K_WARNV, 0, 4'b0000, "rel_warn_blink_low");
        push(s + 1, K_RED,   1, ce(1), "rel_red_cnt1");
        push(s + 1, K_RED,   3, ce(1), "rel_red_cnt3");
        push(s + 1, K_RED,   0, 0, "rel_red_cnt0");
        push(s + 5, K_WARNV, 0, 4'b1110, "rel_warn_blink_high");
        push(s + 5, K_BUZV,  0, 0, "rel_buz");
        step(6);
        sw = '0;
        set_vel(0, 0);
        sync_lights();

        // Overspeed on lane 2, then slow down into HOLD and back to IDLE.
        s = cyc;
        signal_pos = 2'd2;
        sw = 4'b0100;
        set_vel(2, 31);
        push(s + 1,  K_VIS, 2, 1, "spd_vis2");
        push(s + 1,  K_SPD, 2, ce(1), "spd_cnt2");
        push(s + 2,  K_BUZ, 2, 0, "spd_buz_low");
        push(s + 5,  K_BUZ, 2, 1, "spd_buz_high");
        push(s + 9,  K_BUZ, 2, 0, "spd_buz_low2");
        push(s + 13, K_BUZ, 2, 1, "spd_buz_high2");
        step(13);
        set_vel(2, 30);
        push(s + 14, K_BUZ, 2, 1, "hold_buz_high");
        push(s + 15, K_SPD, 2, ce(1), "hold_spd_cnt2");
        push(s + 17, K_BUZ, 2, 0, "hold_buz_low");
        push(s + 20, K_BUZ, 2, 1, "hold_buz_last");
        push(s + 21, K_BUZ, 2, 0, "hold_expired_buz");
        push(s + 21, K_VIS, 2, 1, "hold_expired_vis");
        push(s + 21, K_WARN, 2, 0, "hold_expired_warn");
        step(8);
        sw = '0;
        set_vel(2, 0);
        sync_lights();

        // Red run on lane 3; green arrives -> warning held, then PASS.
        s = cyc;
        signal_pos = 2'd0;
        sw = 4'b1000;
        set_vel(3, 10);
        push(s + 1, K_RED,  3, ce(2), "red_cnt3");
        push(s + 2, K_WARN, 3, 0, "red_warn_low");
        push(s + 5, K_WARN, 3, 1, "red_warn_high");
        push(s + 5, K_BUZ,  3, 0, "red_buz3");
        step(6);
        signal_pos = 2'd3;
        push(s + 7,  K_WARN, 3, 1, "rhold_warn_high");
        push(s + 8,  K_VIS,  3, 1, "rhold_vis3");
        push(s + 9,  K_WARN, 3, 0, "rhold_warn_low");
        push(s + 12, K_WARN, 3, 1, "rhold_warn_last");
        push(s + 14, K_WARN, 3, 0, "pass_warn3");
        push(s + 14, K_RED,  3, ce(2), "pass_red_cnt3");
        push(s + 14, K_VIS,  3, 1, "pass_vis3");
        step(8);
        sw = '0;
        set_vel(3, 0);
        sync_lights();

        // Lane 1 PASS, green moves away -> RED; then lights out mid-HOLD.
        s = cyc;
        signal_pos = 2'd1;
        sw = 4'b0010;
        set_vel(1, 5);
        push(s + 1, K_VIS,  1, 1, "lc_pass_vis1");
        push(s + 1, K_WARN, 1, 0, "lc_pass_warn1");
        step(2);
        signal_pos = 2'd2;
        push(s + 3, K_RED,  1, ce(2), "lc_red_cnt1");
        push(s + 3, K_VIS,  1, 0, "lc_vis1_off");
        push(s + 5, K_WARN, 1, 1, "lc_warn1");
        step(3);
        sw = '0;
        push(s + 6, K_WARN, 1, 1, "lo_hold_warn1");
        step(1);
        lot = 1'b1;
        push(s + 7, K_WARNV, 0, 0, "lo_warn_off");
        push(s + 7, K_BUZV,  0, 0, "lo_buz_off");
        push(s + 7, K_VISV,  0, 0, "lo_vis_off");
        push(s + 7, K_RED,   1, ce(2), "lo_red_cnt1_kept");
        step(1);
        lot = 1'b0;
        push(s + 9,  K_RED,   1, ce(2), "lo_rel_red_cnt1");
        push(s + 9,  K_WARNV, 0, 0, "lo_rel_warn");
        push(s + 13, K_WARNV, 0, 0, "lo_rel_warn_blink_high");
        push(s + 13, K_SPD,   2, ce(1), "lo_rel_spd_cnt2");
        step(6);
        sync_lights();

        // Lane 0 speed entries from HOLD until saturation, then clear.
        s = cyc;
        signal_pos = 2'd0;
        sw = 4'b0001;
        push(s + 1,  K_SPD, 0, ce(1), "sat_cnt_1");
        push(s + 2,  K_BUZ, 0, 0, "sat_buz_low");
        push(s + 3,  K_SPD, 0, ce(2), "sat_cnt_2");
        push(s + 5,  K_SPD, 0, ce(3), "sat_cnt_3");
        push(s + 5,  K_BUZ, 0, 1, "sat_buz_speed");
        push(s + 6,  K_BUZ, 0, 1, "sat_buz_hold");
        push(s + 7,  K_SPD, 0, ce(3), "sat_cnt_saturated");
        push(s + 9,  K_SPD, 0, 0, "clr_spd_cnt0");
        push(s + 9,  K_RED, 3, 0, "clr_red_cnt3");
        push(s + 11, K_SPD, 0, ce(1), "post_clr_cnt");
        for (int k = 0; k < 12; k++) begin
            set_vel(0, (k % 2 == 0) ? 40 : 5);
            clr_cnt = (k == 8);
            step(1);
        end
        clr_cnt = 1'b0;
        sw = '0;
        step(5);

        foreach (sb[j]) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: expected %0d at cycle %0d, still pending", sb[j].name, sb[j].val, sb[j].at);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
